// File: rtl/jtdd_dwnld_remap_pkg.sv
// Shared download memory map for the Double Dragon core: file offsets of each ROM region,
// their SDRAM slots, and the byte-write record passed through the remap queue.
package jtdd_dwnld_remap_pkg;

  localparam logic [21:0] SCR_START  = 22'h05_8000;
  localparam logic [21:0] OBJ_START  = 22'h09_8000;
  localparam logic [21:0] MCU_START  = 22'h11_8000;
  localparam logic [21:0] PRIO_START = 22'h11_C000;
  localparam logic [21:0] FILE_END   = 22'h11_C100;

  localparam logic [21:0] SCR_BASE = 22'h04_0000;
  localparam logic [21:0] OBJ_BASE = 22'h08_0000;
  localparam logic [21:0] MCU_BASE = 22'h0C_0000;

  // Active-low lane enables
  localparam logic [1:0] MASK_LO = 2'b10;
  localparam logic [1:0] MASK_HI = 2'b01;

  typedef enum logic [2:0] {
    RGN_LIN,
    RGN_SCR,
    RGN_OBJ,
    RGN_MCU,
    RGN_PRIO,
    RGN_NONE
  } region_e;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } wr_entry_t;

  function automatic region_e region_of(input logic [21:0] a);
    if (a < SCR_START)       return RGN_LIN;
    else if (a < OBJ_START)  return RGN_SCR;
    else if (a < MCU_START)  return RGN_OBJ;
    else if (a < PRIO_START) return RGN_MCU;
    else if (a < FILE_END)   return RGN_PRIO;
    else                     return RGN_NONE;
  endfunction

endpackage

// File: rtl/jtdd_dwnld_remap_fifo.sv
// Two-entry write queue; a push into a full queue is accepted only when the head pops in the
// same cycle, otherwise it is discarded (the caller flags the overflow).
module jtdd_dwnld_remap_fifo
  import jtdd_dwnld_remap_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wr_entry_t din,
  input  logic      pop,
  output wr_entry_t head,
  output logic      empty,
  output logic      full
);

  wr_entry_t  e0, e1;
  logic [1:0] count;
  logic       push_ok, pop_ok;

  always_comb begin
    push_ok = push & (~full | pop_ok);
    pop_ok  = pop & ~empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) e0 <= din;
          else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = e0;
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/jtdd_dwnld_remap.sv
// Turns the loader byte stream into SDRAM byte-lane writes, relocating scroll/object/MCU
// regions and diverting the priority PROM to its own strobe.
module jtdd_dwnld_remap
  import jtdd_dwnld_remap_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  input  logic        prog_ack,
  output logic        prom_we,
  output logic        ovf,
  output logic        dwnld_done
);

  region_e   rgn;
  logic [21:0] ofs;
  wr_entry_t dec, s1_entry, head;
  logic      s1_valid, s1_prom;
  logic      push, pop, q_empty, q_full;
  logic      prom_hold;
  logic [7:0] prom_addr, prom_data;
  logic      dl_l, done_pend, drained;

  always_comb begin
    rgn      = region_of(ioctl_addr);
    ofs      = '0;
    dec      = '0;
    dec.data = ioctl_data;
    case (rgn)
      RGN_LIN: begin
        dec.addr = {1'b0, ioctl_addr[21:1]};
        dec.mask = ioctl_addr[0] ? MASK_HI : MASK_LO;
      end
      // Tile ROM halves are interleaved: the upper half of each region fills the high lane
      RGN_SCR: begin
        ofs      = ioctl_addr - SCR_START;
        dec.addr = SCR_BASE + {5'd0, ofs[16:0]};
        dec.mask = ofs[17] ? MASK_HI : MASK_LO;
      end
      RGN_OBJ: begin
        ofs      = ioctl_addr - OBJ_START;
        dec.addr = OBJ_BASE + {4'd0, ofs[17:0]};
        dec.mask = ofs[18] ? MASK_HI : MASK_LO;
      end
      RGN_MCU: begin
        ofs      = ioctl_addr - MCU_START;
        dec.addr = MCU_BASE + {1'b0, ofs[21:1]};
        dec.mask = ofs[0] ? MASK_HI : MASK_LO;
      end
      RGN_PRIO: begin
        ofs      = ioctl_addr - PRIO_START;
        dec.addr = {14'd0, ofs[7:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_prom  <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_valid <= ioctl_wr & downloading & (rgn != RGN_NONE);
      s1_prom  <= (rgn == RGN_PRIO);
      s1_entry <= dec;
    end
  end

  // SDRAM handshake: prog_we is high whenever the queue holds an entry and the address,
  // data and mask stay frozen until a cycle with prog_ack=1 retires it; ack without prog_we is ignored.
  assign push    = s1_valid & ~s1_prom;
  assign pop     = prog_ack & prog_we;
  assign prog_we = ~q_empty;

  jtdd_dwnld_remap_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (s1_entry),
    .pop   (pop),
    .head  (head),
    .empty (q_empty),
    .full  (q_full)
  );

  // A PROM byte waits here while an SDRAM write still owns the prog_* bus
  always_ff @(posedge clk) begin
    if (rst) begin
      prom_hold <= 1'b0;
      prom_addr <= 8'd0;
      prom_data <= 8'd0;
    end else begin
      if (prom_we) prom_hold <= 1'b0;
      if (s1_valid && s1_prom) begin
        prom_hold <= 1'b1;
        prom_addr <= s1_entry.addr[7:0];
        prom_data <= s1_entry.data;
      end
    end
  end

  assign prom_we = prom_hold & q_empty;

  always_comb begin
    prog_addr = head.addr;
    prog_data = head.data;
    prog_mask = head.mask;
    if (q_empty) begin
      prog_addr = prom_hold ? {14'd0, prom_addr} : 22'd0;
      prog_data = prom_hold ? prom_data : 8'd0;
      prog_mask = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (push && q_full && !pop) ovf <= 1'b1;
  end

  // Completion waits for the tail of the stream to leave both the decode register and the queue
  assign drained = q_empty & ~s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_l       <= 1'b0;
      done_pend  <= 1'b0;
      dwnld_done <= 1'b0;
    end else begin
      dl_l       <= downloading;
      dwnld_done <= 1'b0;
      if (downloading) done_pend <= 1'b0;
      else if ((dl_l || done_pend) && drained) begin
        dwnld_done <= 1'b1;
        done_pend  <= 1'b0;
      end else if (dl_l) done_pend <= 1'b1;
    end
  end

endmodule
